// File: rtl/voxel_fetch_pkg.sv
// Shared types and constants for the voxel/palette fetch master.
package voxel_fetch_pkg;

    localparam int unsigned AvalonWordBytes = 4;

    typedef enum logic [1:0] {
        FetchIdle,
        FetchIssue,
        FetchDrain
    } fetch_state_t;

endpackage

// File: rtl/voxel_fetch_if.sv
// Avalon-MM pipelined read bus (m1 side) between the fetch master and SDRAM slave.
interface voxel_fetch_if;

    logic [31:0] address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata,
        output readdatavalid
    );

endinterface

// File: rtl/voxel_fetch_sync_fifo.sv
// Synchronous FIFO with occupancy count; head word is read straight from the storage registers.
module voxel_fetch_sync_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 16,
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push_i) - CntW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push_i && !do_pop) begin
            assert (count_q != CntW'(Depth)) else $error("sync_fifo overflow");
        end
    end

endmodule

// File: rtl/voxel_fetch.sv
// Avalon-MM pipelined read master streaming a word array from SDRAM into a local output FIFO.
module voxel_fetch
    import voxel_fetch_pkg::*;
#(
    parameter int unsigned FifoDepth  = 16,
    parameter int unsigned MaxPending = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [31:0]          base_addr_i,
    input  logic [31:0]          word_count_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [31:0]          out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    voxel_fetch_if.master        m1
);

    localparam int unsigned CntW = $clog2(FifoDepth) + 1;

    fetch_state_t    state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     remaining_q, remaining_d;
    logic [CntW-1:0] pending_q, pending_d;
    logic            done_q, done_d;

    logic [CntW-1:0] fifo_count;
    logic            fifo_valid;
    logic [CntW:0]   reserved;
    logic            issue_ok, accept, push, pop, start_ok;

    // Every in-flight read already owns a FIFO slot, so returns can never overflow it.
    assign reserved = {1'b0, pending_q} + {1'b0, fifo_count};
    assign issue_ok = (state_q == FetchIssue) && (remaining_q != '0) &&
                      (pending_q < CntW'(MaxPending)) && (reserved < (CntW + 1)'(FifoDepth));

    assign m1.read    = issue_ok;
    assign m1.address = addr_q;

    assign accept   = issue_ok && !m1.waitrequest;
    // Returns from an abandoned fetch arrive while idle and are dropped.
    assign push     = m1.readdatavalid && (state_q != FetchIdle);
    assign pop      = fifo_valid && out_ready_i;
    assign start_ok = start_i && (state_q == FetchIdle) && !done_q;

    assign pending_d = pending_q + CntW'(accept) - CntW'(push);

    assign busy_o      = (state_q != FetchIdle);
    assign done_o      = done_q;
    assign out_valid_o = fifo_valid;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        case (state_q)
            FetchIdle: begin
                if (start_ok) begin
                    addr_d      = base_addr_i;
                    remaining_d = word_count_i;
                    if (word_count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FetchIssue;
                    end
                end
            end
            FetchIssue: begin
                if (accept) begin
                    addr_d      = addr_q + 32'(AvalonWordBytes);
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) state_d = FetchDrain;
                end
            end
            FetchDrain: begin
                if ((pending_q == '0) && !fifo_valid) begin
                    done_d  = 1'b1;
                    state_d = FetchIdle;
                end
            end
            default: state_d = FetchIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FetchIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            pending_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
        end
    end

    voxel_fetch_sync_fifo #(
        .Width (32),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (m1.readdata),
        .pop_i   (pop),
        .data_o  (out_data_o),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_voxel_fetch.sv
// Directed + randomized bench for voxel_fetch with an Avalon slave model and word scoreboard.
module tb_voxel_fetch;

    localparam int unsigned FifoDepth  = 16;
    localparam int unsigned MaxPending = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [31:0] word_count_i = '0;
    logic        busy_o, done_o, out_valid_o;
    logic [31:0] out_data_o;
    logic        out_ready_i = 1'b0;

    voxel_fetch_if m1 ();

    voxel_fetch #(
        .FifoDepth  (FifoDepth),
        .MaxPending (MaxPending)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .word_count_i (word_count_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .m1           (m1)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        rq[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 2;
    int unsigned wait_pct = 0;
    int          reads_issued = 0;
    int          done_cnt = 0;
    bit          ready_en = 1'b0;
    bit          rand_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // SDRAM slave, consumer and scoreboard; inputs change on the falling edge.
    always @(negedge clk_i) begin
        cyc++;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            m1.readdatavalid = 1'b1;
            m1.readdata      = mem_word(rq[0].addr);
            void'(rq.pop_front());
        end else begin
            m1.readdatavalid = 1'b0;
            m1.readdata      = '0;
        end
        m1.waitrequest = (wait_pct > 0) && ($urandom_range(99) < wait_pct);
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_read", 32'(m1.read), 32'd1);
                chk("stall_addr", m1.address, prev_addr);
            end
            if (m1.read && !m1.waitrequest) begin
                reads_issued++;
                if (exp_addr.size() == 0) chk("extra_read", 32'(exp_addr.size()), 32'd1);
                else chk("read_addr", m1.address, exp_addr.pop_front());
                rq.push_back('{m1.address, cyc + lat});
                chk("pending_max", 32'(rq.size() <= MaxPending), 32'd1);
            end
            prev_stall = m1.read && m1.waitrequest;
            prev_addr  = m1.address;
            if (done_o) done_cnt++;
        end
        out_ready_i = ready_en && (!rand_ready || ($urandom_range(1) == 1));
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (exp_data.size() == 0) chk("extra_word", 32'(exp_data.size()), 32'd1);
            else chk("out_data", out_data_o, exp_data.pop_front());
        end
    end

    task automatic start_fetch(logic [31:0] base, logic [31:0] count);
        @(negedge clk_i);
        start_i      = 1'b1;
        base_addr_i  = base;
        word_count_i = count;
        for (int i = 0; i < int'(count); i++) begin
            exp_addr.push_back(base + 32'(4 * i));
            exp_data.push_back(mem_word(base + 32'(4 * i)));
        end
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(int budget, string tag);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!done_o && n < budget);
        #1;
        chk(tag, 32'(done_o), 32'd1);
        chk({tag, "_busy_low"}, 32'(busy_o), 32'd0);
        chk({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
        chk({tag, "_data_left"}, 32'(exp_data.size()), 32'd0);
    endtask

    initial begin
        int          r0;
        logic [31:0] b;

        #12;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_read", 32'(m1.read), 32'd0);
        chk("rst_addr", m1.address, 32'd0);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Basic 4-word fetch, no stalls.
        ready_en = 1'b1;
        start_fetch(32'h0800_0000, 32'd4);
        chk("t1_busy", 32'(busy_o), 32'd1);
        wait_done(100, "t1_done");
        // Start coinciding with done must be ignored.
        start_i      = 1'b1;
        base_addr_i  = 32'h0000_1000;
        word_count_i = 32'd5;
        r0 = reads_issued;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("t1_done_single", 32'(done_o), 32'd0);
        chk("t1_start_ignored", 32'(busy_o), 32'd0);
        repeat (5) @(negedge clk_i);
        #1;
        chk("t1_no_reads", 32'(reads_issued - r0), 32'd0);

        // Zero-length fetch.
        r0 = reads_issued;
        start_fetch(32'h0000_2000, 32'd0);
        chk("t2_done", 32'(done_o), 32'd1);
        chk("t2_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        #1;
        chk("t2_done_pulse", 32'(done_o), 32'd0);
        chk("t2_no_reads", 32'(reads_issued - r0), 32'd0);

        // Consumer stalled: issue stops once the FIFO is fully reserved.
        ready_en = 1'b0;
        r0 = reads_issued;
        start_fetch(32'h0800_1000, 32'd40);
        repeat (60) @(negedge clk_i);
        #1;
        chk("t3_reads_stalled", 32'(reads_issued - r0), 32'(FifoDepth));
        chk("t3_read_low", 32'(m1.read), 32'd0);
        chk("t3_valid", 32'(out_valid_o), 32'd1);
        ready_en = 1'b1;
        wait_done(600, "t3_done");
        chk("t3_reads_total", 32'(reads_issued - r0), 32'd40);

        // Random waitrequest, random consumer, long latency to reach the pending limit.
        wait_pct   = 50;
        rand_ready = 1'b1;
        lat        = 10;
        b = $urandom & 32'hFFFF_FFFC;
        start_fetch(b, 32'd30);
        wait_done(3000, "t4_done");
        wait_pct   = 0;
        rand_ready = 1'b0;
        lat        = 2;

        // Address wrap at 2^32.
        start_fetch(32'hFFFF_FFF8, 32'd4);
        wait_done(100, "t5_done");

        // Reset with reads in flight; stale returns arrive while idle.
        lat = 6;
        start_fetch(32'h0300_0000, 32'd20);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            #1;
            if (rq.size() >= 3) break;
        end
        chk("t6_pending3", 32'(rq.size()), 32'd3);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        chk("t6_rst_done", 32'(done_o), 32'd0);
        chk("t6_rst_read", 32'(m1.read), 32'd0);
        chk("t6_rst_addr", m1.address, 32'd0);
        chk("t6_rst_valid", 32'(out_valid_o), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            #1;
            if (rq.size() == 0) break;
        end
        repeat (2) @(negedge clk_i);
        #1;
        chk("t6_stale_dropped", 32'(out_valid_o), 32'd0);
        chk("t6_idle", 32'(busy_o), 32'd0);
        lat = 2;
        start_fetch(32'h0400_0000, 32'd2);
        wait_done(100, "t6_done");

        repeat (3) @(negedge clk_i);
        #1;
        chk("done_total", 32'(done_cnt), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
